uart_rx_oversampled: RTL

Oversampling UART receiver, 8N1, LSB first. It is the far-end peer for frames produced by the existing transmitter: start bit 0, eight data bits, stop bit 1. The serial line is synchronised, then majority-voted at mid-bit using the baud generator's `ticks` strobe (OVERSAMPLE per bit). Accepted bytes are handed off through a one-entry valid/ready holding register with framing and overrun flags. It is instantiated beside the existing transmitter in the UART top, fed by `ticks` from the baud generator.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync.sv | 28 ++
 rtl/uart_rx_oversampled.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width,
// default oversampling ratio and the idle level of the serial line.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    localparam int DATA_BITS          = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam logic idle_level       = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports:
//   clk    system clock
//   reset  synchronous, active-low reset (both flops load RESET_VALUE)
//   d      asynchronous input
//   q      synchronised output
module uart_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling 8N1 UART receiver (LSB first) with 3-sample mid-bit
// majority vote and a one-entry valid/ready holding register.
// Ports:
//   clk         system clock
//   reset       synchronous, active-low reset
//   ticks       one-clk strobe at OVERSAMPLE x baud
//   rx_enable   receive enable; low aborts a frame in progress
//   rx_input    asynchronous serial line, idle high
//   rx_ready    consumer accepts rx_data while rx_valid is high
//   err_clear   one-clk pulse clearing rx_error and rx_overrun
//   rx_data     received byte
//   rx_valid    holding register full
//   rx_busy     frame in progress
//   rx_error    sticky framing error
//   rx_overrun  sticky; good frame dropped because holding register full
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for a falling edge on the synchronised line
// ST_START | start bit; vote of 1 means it was a glitch
// ST_DATA  | eight data bits, shifted into shreg LSB first
// ST_STOP  | stop bit; leaves at the vote so the next edge is not missed
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ticks,
    input  logic                 rx_enable,
    input  logic                 rx_input,
    input  logic                 rx_ready,
    input  logic                 err_clear,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 rx_error,
    output logic                 rx_overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] SAMPLE_FIRST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SAMPLE_MID   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] SAMPLE_LAST  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST     = CW'(OVERSAMPLE - 1);
    localparam logic [2:0]    IDX_LAST     = 3'(DATA_BITS - 1);

    rx_state_t            state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [2:0]           idx, idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 samp_a, samp_a_nxt;
    logic                 samp_b, samp_b_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_nxt, error_nxt, overrun_nxt;

    logic rx_sync, rx_prev;
    logic fall, vote, resolve, wrap;
    logic good_frame, bad_frame, load, accept, overrun_set;

    uart_sync #(.RESET_VALUE(idle_level)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_input),
        .q     (rx_sync)
    );

    assign fall    = rx_prev & ~rx_sync;
    // Third sample is taken live at the resolving tick.
    assign vote    = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
    assign resolve = ticks && (cnt == SAMPLE_LAST);
    assign wrap    = ticks && (cnt == CNT_LAST);
    assign rx_busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            samp_a     <= idle_level;
            samp_b     <= idle_level;
            rx_prev    <= idle_level;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shreg      <= shreg_nxt;
            samp_a     <= samp_a_nxt;
            samp_b     <= samp_b_nxt;
            rx_prev    <= rx_sync;
            rx_data    <= data_nxt;
            rx_valid   <= valid_nxt;
            rx_error   <= error_nxt;
            rx_overrun <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        shreg_nxt  = shreg;
        samp_a_nxt = samp_a;
        samp_b_nxt = samp_b;
        good_frame = 1'b0;
        bad_frame  = 1'b0;

        if (ticks && state != ST_IDLE) begin
            // OVERSAMPLE is a power of two, so the counter wraps naturally.
            cnt_nxt = cnt + 1'b1;
            if (cnt == SAMPLE_FIRST) samp_a_nxt = rx_sync;
            if (cnt == SAMPLE_MID)   samp_b_nxt = rx_sync;
        end

        unique case (state)
            ST_IDLE: begin
                if (fall && rx_enable) begin
                    state_nxt = ST_START;
                    cnt_nxt   = '0;
                end
            end
            ST_START: begin
                if (resolve && vote) begin
                    state_nxt = ST_IDLE;
                end else if (wrap) begin
                    state_nxt = ST_DATA;
                    idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (resolve) shreg_nxt = {vote, shreg[DATA_BITS-1:1]};
                if (wrap) begin
                    if (idx == IDX_LAST) state_nxt = ST_STOP;
                    else                 idx_nxt   = idx + 3'd1;
                end
            end
            ST_STOP: begin
                if (resolve) begin
                    state_nxt  = ST_IDLE;
                    good_frame = vote;
                    bad_frame  = ~vote;
                end
            end
        endcase

        if (state != ST_IDLE && !rx_enable) begin
            state_nxt  = ST_IDLE;
            good_frame = 1'b0;
            bad_frame  = 1'b0;
        end
    end

    // A consumer accepting in the same cycle frees the slot for the new byte.
    assign accept      = rx_valid & rx_ready;
    assign load        = good_frame & (~rx_valid | rx_ready);
    assign overrun_set = good_frame & rx_valid & ~rx_ready;

    always_comb begin
        data_nxt    = load ? shreg : rx_data;
        valid_nxt   = load ? 1'b1 : (accept ? 1'b0 : rx_valid);
        error_nxt   = bad_frame ? 1'b1 : (err_clear ? 1'b0 : rx_error);
        overrun_nxt = overrun_set ? 1'b1 : (err_clear ? 1'b0 : rx_overrun);
    end

endmodule
